// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the byte-wide memory port arbiter.
package mem_arbiter_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_COOL   = 3'd1;
  localparam logic [2:0] ST_READ   = 3'd2;
  localparam logic [2:0] ST_WRITE  = 3'd3;
  localparam logic [2:0] ST_IOWAIT = 3'd4;

  localparam logic True    = 1'b1;
  localparam logic False   = 1'b0;
  localparam logic Enable  = 1'b1;
  localparam logic Disable = 1'b0;

  localparam logic [1:0] IO_ADDR_HI = 2'b11;

  localparam logic [2:0] LEN_1 = 3'd1;
  localparam logic [2:0] LEN_2 = 3'd2;
  localparam logic [2:0] LEN_4 = 3'd4;

  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_LS = 1'b1;

  // Unsupported length codes fall back to a full word so every transfer terminates.
  function automatic logic [2:0] norm_len(input logic [2:0] len);
    case (len)
      LEN_1:   return LEN_1;
      LEN_2:   return LEN_2;
      default: return LEN_4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Owns the byte-wide RAM/IO port: serialises ICache fetches and LSB loads/stores
// into byte accesses and returns assembled words with a one-cycle success pulse.
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter logic [1:0]  IO_ADDR_HI = mem_arbiter_pkg::IO_ADDR_HI
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  input  logic              IC_S,
  input  logic [ADDR_W-1:0] IC_pc,
  output logic              IC_success,
  output logic [DATA_W-1:0] IC_Inst,
  input  logic              LS_S,
  input  logic              LS_wr,
  input  logic [2:0]        LS_len,
  input  logic [ADDR_W-1:0] LS_addr,
  input  logic [DATA_W-1:0] LS_data,
  output logic              LS_success,
  output logic [DATA_W-1:0] LS_result,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);
  import mem_arbiter_pkg::*;

  logic [2:0]        r_state, w_state;
  logic [2:0]        r_cnt, w_cnt;
  logic [2:0]        r_len, w_len;
  logic              r_owner, w_owner;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [DATA_W-1:0] r_data, w_data;
  logic [3:0][7:0]   r_bytes, w_bytes;
  logic [ADDR_W-1:0] r_mem_a, w_mem_a;
  logic [7:0]        r_mem_dout, w_mem_dout;
  logic              r_mem_wr, w_mem_wr;
  logic              r_ic_success, w_ic_success;
  logic              r_ls_success, w_ls_success;
  logic [DATA_W-1:0] r_ic_inst, w_ic_inst;
  logic [DATA_W-1:0] r_ls_result, w_ls_result;
  logic [2:0]        w_cnt_inc;
  logic [31:0]       w_assembled;
  logic              w_ls_io;

  assign w_cnt_inc = r_cnt + 3'd1;
  assign w_ls_io   = (LS_addr[17:16] == IO_ADDR_HI);

  // Bytes already captured, the byte arriving now, and zeros above the transfer length.
  always_comb begin
    w_assembled = '0;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) == r_cnt) begin
        w_assembled[8*i +: 8] = mem_din;
      end else if (3'(i) < r_cnt) begin
        w_assembled[8*i +: 8] = r_bytes[i];
      end
    end
  end

  always_comb begin
    w_state      = r_state;
    w_cnt        = r_cnt;
    w_len        = r_len;
    w_owner      = r_owner;
    w_addr       = r_addr;
    w_data       = r_data;
    w_bytes      = r_bytes;
    w_mem_a      = r_mem_a;
    w_mem_dout   = r_mem_dout;
    w_mem_wr     = Disable;
    w_ic_success = False;
    w_ls_success = False;
    w_ic_inst    = r_ic_inst;
    w_ls_result  = r_ls_result;

    case (r_state)
      ST_IDLE: begin
        if (!clear) begin
          if (LS_S) begin
            w_owner = OWN_LS;
            w_addr  = LS_addr;
            w_len   = norm_len(LS_len);
            w_data  = LS_data;
            if (LS_wr && w_ls_io) begin
              w_state = ST_IOWAIT;
            end else if (LS_wr) begin
              w_mem_a    = LS_addr;
              w_mem_dout = LS_data[7:0];
              w_mem_wr   = Enable;
              w_cnt      = 3'd1;
              w_state    = ST_WRITE;
            end else begin
              w_mem_a = LS_addr;
              w_cnt   = 3'd0;
              w_state = ST_READ;
            end
          end else if (IC_S) begin
            w_owner = OWN_IC;
            w_addr  = IC_pc;
            w_len   = LEN_4;
            w_mem_a = IC_pc;
            w_cnt   = 3'd0;
            w_state = ST_READ;
          end
        end
      end

      ST_READ: begin
        if (clear) begin
          w_state = ST_IDLE;
        end else begin
          w_bytes[r_cnt[1:0]] = mem_din;
          if (w_cnt_inc < r_len) begin
            w_mem_a = r_addr + ADDR_W'(w_cnt_inc);
            w_cnt   = w_cnt_inc;
          end else begin
            w_state = ST_COOL;
            if (r_owner == OWN_IC) begin
              w_ic_success = True;
              w_ic_inst    = DATA_W'(w_assembled);
            end else begin
              w_ls_success = True;
              w_ls_result  = DATA_W'(w_assembled);
            end
          end
        end
      end

      // Stores are committed: clear has no effect here or in ST_IOWAIT.
      ST_WRITE: begin
        if (r_cnt < r_len) begin
          w_mem_a    = r_addr + ADDR_W'(r_cnt);
          w_mem_dout = r_data[{r_cnt[1:0], 3'b000} +: 8];
          w_mem_wr   = Enable;
          w_cnt      = w_cnt_inc;
        end else begin
          w_ls_success = True;
          w_state      = ST_COOL;
        end
      end

      ST_IOWAIT: begin
        if (!io_buffer_full) begin
          w_mem_a    = r_addr;
          w_mem_dout = r_data[7:0];
          w_mem_wr   = Enable;
          w_cnt      = 3'd1;
          w_state    = ST_WRITE;
        end
      end

      // Requesters still hold their level while sampling success, so no grant here.
      ST_COOL: w_state = ST_IDLE;

      default: w_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_len        <= '0;
      r_owner      <= OWN_IC;
      r_addr       <= '0;
      r_data       <= '0;
      r_bytes      <= '0;
      r_mem_a      <= '0;
      r_mem_dout   <= '0;
      r_mem_wr     <= Disable;
      r_ic_success <= False;
      r_ls_success <= False;
      r_ic_inst    <= '0;
      r_ls_result  <= '0;
    end else if (rdy) begin
      r_state      <= w_state;
      r_cnt        <= w_cnt;
      r_len        <= w_len;
      r_owner      <= w_owner;
      r_addr       <= w_addr;
      r_data       <= w_data;
      r_bytes      <= w_bytes;
      r_mem_a      <= w_mem_a;
      r_mem_dout   <= w_mem_dout;
      r_mem_wr     <= w_mem_wr;
      r_ic_success <= w_ic_success;
      r_ls_success <= w_ls_success;
      r_ic_inst    <= w_ic_inst;
      r_ls_result  <= w_ls_result;
    end
  end

  assign mem_a      = r_mem_a;
  assign mem_dout   = r_mem_dout;
  assign mem_wr     = r_mem_wr & rdy;
  assign IC_success = r_ic_success & rdy;
  assign LS_success = r_ls_success & rdy;
  assign IC_Inst    = r_ic_inst;
  assign LS_result  = r_ls_result;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized transfers
// checked against a byte-addressed memory model and per-cycle protocol expectations.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        clear;
  logic        IC_S;
  logic [31:0] IC_pc;
  logic        IC_success;
  logic [31:0] IC_Inst;
  logic        LS_S;
  logic        LS_wr;
  logic [2:0]  LS_len;
  logic [31:0] LS_addr;
  logic [31:0] LS_data;
  logic        LS_success;
  logic [31:0] LS_result;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  int n_checks = 0;
  int n_errors = 0;

  // ram: what the DUT actually wrote/read; model_mem: what the spec says memory should hold.
  logic [7:0] ram       [logic [31:0]];
  logic [7:0] model_mem [logic [31:0]];

  mem_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .clear          (clear),
    .IC_S           (IC_S),
    .IC_pc          (IC_pc),
    .IC_success     (IC_success),
    .IC_Inst        (IC_Inst),
    .LS_S           (LS_S),
    .LS_wr          (LS_wr),
    .LS_len         (LS_len),
    .LS_addr        (LS_addr),
    .LS_data        (LS_data),
    .LS_success     (LS_success),
    .LS_result      (LS_result),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no summary, required completion");
    $fatal(1);
  end

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return 8'h00;
  endfunction

  function automatic logic [7:0] mdl_rd(input logic [31:0] a);
    if (model_mem.exists(a)) return model_mem[a];
    return 8'h00;
  endfunction

  function automatic logic [31:0] mdl_word(input logic [31:0] a, input int len);
    logic [31:0] w;
    w = 32'h0;
    for (int i = 0; i < len; i++) w |= 32'(mdl_rd(a + 32'(i))) << (8 * i);
    return w;
  endfunction

  task automatic poke(input logic [31:0] a, input logic [7:0] b);
    ram[a]       = b;
    model_mem[a] = b;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock: RAM services the cycle's access at the negedge, inputs change just after.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (mem_wr) ram[mem_a] = mem_dout;
    mem_din = ram_rd(mem_a);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_mem_a"}, mem_a, 32'h0);
    chk({tag, "_mem_dout"}, 32'(mem_dout), 32'h0);
    chk({tag, "_mem_wr"}, 32'(mem_wr), 32'h0);
    chk({tag, "_ic_success"}, 32'(IC_success), 32'h0);
    chk({tag, "_ls_success"}, 32'(LS_success), 32'h0);
    chk({tag, "_ic_inst"}, IC_Inst, 32'h0);
    chk({tag, "_ls_result"}, LS_result, 32'h0);
  endtask

  // Full request/response handshake with per-edge expectations from the transfer rules.
  task automatic xfer(input bit is_ic, input bit wr, input int len, input logic [31:0] addr,
                      input logic [31:0] data, input int full_cycles, input int clear_k);
    bit          io;
    logic [31:0] exp;
    io  = wr && (addr[17:16] == 2'b11);
    exp = mdl_word(addr, len);
    if (is_ic) begin
      IC_S  = 1'b1;
      IC_pc = addr;
    end else begin
      LS_S    = 1'b1;
      LS_wr   = wr;
      LS_len  = 3'(len);
      LS_addr = addr;
      LS_data = data;
    end
    if (io) begin
      io_buffer_full = (full_cycles > 0);
      tick();
      chk("io_wait_wr", 32'(mem_wr), 32'h0);
      for (int j = 1; j < full_cycles; j++) begin
        tick();
        chk("io_wait_wr", 32'(mem_wr), 32'h0);
        chk("io_wait_succ", 32'(LS_success), 32'h0);
      end
      io_buffer_full = 1'b0;
    end
    for (int k = 0; k < len; k++) begin
      clear = (k == clear_k);
      tick();
      chk("byte_addr", mem_a, addr + 32'(k));
      chk("byte_wr", 32'(mem_wr), 32'(wr));
      if (wr) chk("byte_dout", 32'(mem_dout), 32'(data[8*k +: 8]));
      chk("early_succ", 32'(IC_success | LS_success), 32'h0);
    end
    clear = 1'b0;
    tick();
    chk("done_wr", 32'(mem_wr), 32'h0);
    if (is_ic) begin
      chk("ic_success", 32'(IC_success), 32'h1);
      chk("ls_quiet", 32'(LS_success), 32'h0);
      chk("ic_inst", IC_Inst, exp);
    end else begin
      chk("ls_success", 32'(LS_success), 32'h1);
      chk("ic_quiet", 32'(IC_success), 32'h0);
      if (!wr) chk("ls_result", LS_result, exp);
    end
    tick();
    chk("cool_succ", 32'(IC_success | LS_success), 32'h0);
    chk("cool_no_grant", mem_a, addr + 32'(len - 1));
    chk("cool_wr", 32'(mem_wr), 32'h0);
    IC_S = 1'b0;
    LS_S = 1'b0;
    if (wr) begin
      for (int i = 0; i < len; i++) model_mem[addr + 32'(i)] = data[8*i +: 8];
      for (int i = -1; i <= len; i++)
        chk("ram_after_store", 32'(ram_rd(addr + 32'(i))), 32'(mdl_rd(addr + 32'(i))));
    end
  endtask

  int          sel;
  int          len;
  int          fc;
  int          ck;
  bit          wr;
  logic [31:0] a;
  logic [31:0] d;
  logic [31:0] exp_w;

  initial begin
    rst = 1'b1; rdy = 1'b1; clear = 1'b0;
    IC_S = 1'b0; IC_pc = '0;
    LS_S = 1'b0; LS_wr = 1'b0; LS_len = 3'd1; LS_addr = '0; LS_data = '0;
    mem_din = '0; io_buffer_full = 1'b0;

    poke(32'h1000, 8'h13); poke(32'h1001, 8'h05); poke(32'h1002, 8'h00); poke(32'h1003, 8'h00);
    poke(32'h1004, 8'h93); poke(32'h1005, 8'h00); poke(32'h1006, 8'h10); poke(32'h1007, 8'h00);
    poke(32'h2001, 8'hAA); poke(32'h2002, 8'hBB);
    for (int i = 0; i < 48; i++) poke(32'h4000 + 32'(i), 8'($urandom));
    for (int i = -2; i < 2; i++) poke(32'(i), 8'($urandom));

    tick(); tick();
    chk_reset_state("reset");
    rst = 1'b0;
    tick();

    // Fetch, with COOL re-grant guard inside xfer.
    xfer(1'b1, 1'b0, 4, 32'h1000, 32'h0, 0, -1);
    chk("fetch_word", IC_Inst, 32'h00000513);

    // Contention: LSB first, fetch granted on the first IDLE edge after COOL.
    LS_S = 1'b1; LS_wr = 1'b0; LS_len = 3'd2; LS_addr = 32'h2001;
    IC_S = 1'b1; IC_pc = 32'h1000;
    tick(); chk("cont_a0", mem_a, 32'h2001);
    tick(); chk("cont_a1", mem_a, 32'h2002);
    tick();
    chk("cont_ls_succ", 32'(LS_success), 32'h1);
    chk("cont_ls_result", LS_result, 32'h0000BBAA);
    chk("cont_ic_wait", 32'(IC_success), 32'h0);
    tick();
    chk("cont_cool", mem_a, 32'h2002);
    LS_S = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("cont_fetch_a", mem_a, 32'h1000 + 32'(k));
    end
    tick();
    chk("cont_ic_succ", 32'(IC_success), 32'h1);
    chk("cont_ic_inst", IC_Inst, 32'h00000513);
    tick();
    chk("cont_ic_cool", 32'(IC_success), 32'h0);
    IC_S = 1'b0;

    // Store, I/O store held off by a full buffer, store that ignores clear.
    xfer(1'b0, 1'b1, 4, 32'h3000, 32'hDEADBEEF, 0, -1);
    xfer(1'b0, 1'b1, 1, 32'h00030000, 32'h00000041, 5, -1);
    xfer(1'b0, 1'b1, 4, 32'h3100, 32'hCAFEF00D, 0, 2);

    // clear in IDLE suppresses the grant for that edge.
    LS_S = 1'b1; LS_wr = 1'b1; LS_len = 3'd1; LS_addr = 32'h5000; LS_data = 32'h77;
    clear = 1'b1;
    tick();
    chk("idle_clear_wr", 32'(mem_wr), 32'h0);
    chk("idle_clear_a", mem_a, 32'h3103);
    clear = 1'b0;
    xfer(1'b0, 1'b1, 1, 32'h5000, 32'h77, 0, -1);

    // Fetch flushed during its 2nd byte, then an immediate fresh fetch.
    IC_S = 1'b1; IC_pc = 32'h1000;
    tick(); tick();
    chk("flush_a1", mem_a, 32'h1001);
    clear = 1'b1;
    tick();
    chk("flush_no_succ", 32'(IC_success), 32'h0);
    chk("flush_halt", mem_a, 32'h1001);
    clear = 1'b0; IC_S = 1'b0;
    tick();
    chk("flush_quiet", 32'(IC_success), 32'h0);
    xfer(1'b1, 1'b0, 4, 32'h1004, 32'h0, 0, -1);

    // rdy low mid-load freezes progress; rdy low in COOL masks success.
    exp_w = mdl_word(32'h4010, 4);
    LS_S = 1'b1; LS_wr = 1'b0; LS_len = 3'd4; LS_addr = 32'h4010;
    tick(); tick();
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rdy_hold_a", mem_a, 32'h4011);
      chk("rdy_hold_wr", 32'(mem_wr), 32'h0);
      chk("rdy_hold_succ", 32'(LS_success), 32'h0);
    end
    rdy = 1'b1;
    tick(); chk("rdy_resume_a2", mem_a, 32'h4012);
    tick(); chk("rdy_resume_a3", mem_a, 32'h4013);
    tick();
    chk("rdy_load_succ", 32'(LS_success), 32'h1);
    chk("rdy_load_result", LS_result, exp_w);
    rdy = 1'b0; #1;
    chk("rdy_mask_succ", 32'(LS_success), 32'h0);
    tick();
    rdy = 1'b1; #1;
    chk("rdy_cool_held", 32'(LS_success), 32'h1);
    tick();
    chk("rdy_cool_end", 32'(LS_success), 32'h0);
    LS_S = 1'b0;

    // rdy low mid-store forces mem_wr low without losing the byte.
    LS_S = 1'b1; LS_wr = 1'b1; LS_len = 3'd2; LS_addr = 32'h6000; LS_data = 32'h1234;
    tick();
    chk("rdy_st_wr0", 32'(mem_wr), 32'h1);
    rdy = 1'b0; #1;
    chk("rdy_st_forced", 32'(mem_wr), 32'h0);
    tick(); tick();
    chk("rdy_st_hold_wr", 32'(mem_wr), 32'h0);
    chk("rdy_st_hold_a", mem_a, 32'h6000);
    rdy = 1'b1; #1;
    chk("rdy_st_back", 32'(mem_wr), 32'h1);
    tick();
    chk("rdy_st_a1", mem_a, 32'h6001);
    chk("rdy_st_d1", 32'(mem_dout), 32'h12);
    tick();
    chk("rdy_st_succ", 32'(LS_success), 32'h1);
    tick();
    LS_S = 1'b0;
    model_mem[32'h6000] = 8'h34;
    model_mem[32'h6001] = 8'h12;
    chk("rdy_st_ram0", 32'(ram_rd(32'h6000)), 32'(mdl_rd(32'h6000)));
    chk("rdy_st_ram1", 32'(ram_rd(32'h6001)), 32'(mdl_rd(32'h6001)));

    // Reset mid-fetch drops the transfer with no success pulse.
    IC_S = 1'b1; IC_pc = 32'h1000;
    tick(); tick();
    rst = 1'b1;
    tick();
    chk_reset_state("midrst");
    rst = 1'b0; IC_S = 1'b0;
    tick(); tick();
    chk("midrst_no_succ", 32'(IC_success), 32'h0);
    chk("midrst_idle_a", mem_a, 32'h0);
    xfer(1'b1, 1'b0, 4, 32'h1000, 32'h0, 0, -1);

    // Randomized traffic against the memory model.
    for (int it = 0; it < 40; it++) begin
      sel = $urandom_range(0, 9);
      case ($urandom_range(0, 2))
        0:       len = 1;
        1:       len = 2;
        default: len = 4;
      endcase
      wr = 1'($urandom);
      d  = $urandom;
      fc = $urandom_range(0, 4);
      if (sel <= 2) begin
        xfer(1'b1, 1'b0, 4, 32'h4000 + 32'($urandom_range(0, 40)), 32'h0, 0, -1);
      end else begin
        if (sel <= 6) a = 32'h4000 + 32'($urandom_range(0, 40));
        else if (sel == 7) a = 32'hFFFFFFFE;
        else a = 32'h00030000 + 32'($urandom_range(0, 3));
        ck = wr ? $urandom_range(1, 4) : -1;
        xfer(1'b0, wr, len, a, d, fc, ck);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
